// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter: round-robin wormhole scheduler for one router output with credit flow control (optional LOCK_TIMEOUT_EN forces release of an idle owner)
module rr_output_arbiter #(
    parameter int NPORTS      = 5,
    parameter int MAX_CREDITS = 4,
    parameter int CREDIT_W    = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORTS-1:0]   req_i,
    input  logic [NPORTS-1:0]   head_i,
    input  logic [NPORTS-1:0]   tail_i,
    input  logic                credit_incr_i,
    output logic [NPORTS-1:0]   grant_o,
    output logic                locked_o,
    output logic [2:0]          owner_o,
    output logic [CREDIT_W-1:0] credits_o,
`ifdef LOCK_TIMEOUT_EN
    output logic                timeout_o,
`endif
    output logic                credit_err_o
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state_q, state_d;
    logic [2:0] ptr_q, ptr_d, owner_q, owner_d, win, idx;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic err_q, err_d, found, have_cred;
`ifdef LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic to_q, to_d;
    assign timeout_o = to_q;
`endif
    assign locked_o     = state_q == LOCKED;
    assign owner_o      = owner_q;
    assign credits_o    = credits_q;
    assign credit_err_o = err_q;
    assign have_cred    = credits_q != '0;
    // head-flit winner: first eligible port after ptr, scanned backwards so the nearest one wins
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = 3'((int'(ptr_q) + k) % NPORTS);
            if (req_i[idx] && head_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    // grant, lock tracking, priority pointer and credit accounting
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_o   = '0;
        credits_d = credits_q;
        err_d     = err_q;
        if (state_q == IDLE) begin
            if (found && have_cred) begin
                grant_o[win] = 1'b1;
                owner_d      = win;
                if (tail_i[win]) ptr_d = win;
                else state_d = LOCKED;
            end
        end else if (req_i[owner_q] && have_cred) begin
            grant_o[owner_q] = 1'b1;
            if (tail_i[owner_q]) begin
                state_d = IDLE;
                ptr_d   = owner_q;
            end
        end
`ifdef LOCK_TIMEOUT_EN
        cnt_d = (state_q == LOCKED && !req_i[owner_q]) ? cnt_q + 1'b1 : '0;
        to_d  = 1'b0;
        if (state_q == LOCKED && !req_i[owner_q] && cnt_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ptr_d   = owner_q;
            cnt_d   = '0;
            to_d    = 1'b1;
        end
`endif
        if (|grant_o && !credit_incr_i) credits_d = credits_q - 1'b1;
        else if (credit_incr_i && !(|grant_o)) begin
            if (credits_q == CREDIT_W'(MAX_CREDITS)) err_d = 1'b1;
            else credits_d = credits_q + 1'b1;
        end
    end
    // state registers; pointer resets to the last port so port 0 leads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'(NPORTS - 1);
            owner_q   <= '0;
            credits_q <= CREDIT_W'(MAX_CREDITS);
            err_q     <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
            cnt_q     <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
            err_q     <= err_d;
`ifdef LOCK_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_q      <= to_d;
`endif
        end
    end
endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb_rr_output_arbiter: directed and randomized checks of rr_output_arbiter against a packet-level reference model
module tb_rr_output_arbiter;
    logic clk = 0, rst = 0, credit_incr_i = 0;
    logic [4:0] req_i = 0, head_i = 0, tail_i = 0, grant_o;
    logic locked_o, credit_err_o;
    logic [2:0] owner_o, credits_o;
    int vectors = 0, miscompares = 0;
    int m_ptr, m_owner, m_locked, m_cred, m_err;

    rr_output_arbiter dut (
        .clk(clk), .rst(rst), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
        .credit_incr_i(credit_incr_i), .grant_o(grant_o), .locked_o(locked_o),
        .owner_o(owner_o), .credits_o(credits_o), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    // who should transfer this cycle, from the rules: round-robin among heads when free, owner only when locked
    function automatic logic [4:0] m_grant();
        if (m_cred == 0) return 5'b0;
        if (m_locked) return req_i[m_owner] ? 5'(1 << m_owner) : 5'b0;
        for (int k = 1; k <= 5; k++) begin
            int p = (m_ptr + k) % 5;
            if (req_i[p] && head_i[p]) return 5'(1 << p);
        end
        return 5'b0;
    endfunction

    task automatic drive(input logic [4:0] r, h, t, input logic inc);
        req_i = r; head_i = h; tail_i = t; credit_incr_i = inc;
        #3;
    endtask

    task automatic tick();
        logic [4:0] g = m_grant();
        int w = 0;
        for (int i = 0; i < 5; i++) if (g[i]) w = i;
        @(posedge clk);
        if (g != 0) begin
            if (!m_locked) begin
                m_owner = w;
                if (tail_i[w]) m_ptr = w; else m_locked = 1;
            end else if (tail_i[w]) begin
                m_locked = 0; m_ptr = w;
            end
        end
        if (g != 0 && !credit_incr_i) m_cred--;
        else if (credit_incr_i && g == 0) begin
            if (m_cred == 4) m_err = 1; else m_cred++;
        end
        #1;
    endtask

    task automatic do_reset();
        req_i = 0; head_i = 0; tail_i = 0; credit_incr_i = 0;
        rst = 1; #2; rst = 0;
        m_ptr = 4; m_owner = 0; m_locked = 0; m_cred = 4; m_err = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0);
        vectors++;
        if ({grant_o, locked_o, owner_o, credits_o, credit_err_o} !== {5'b0, 1'b0, 3'd0, 3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got g=%b l=%b o=%0d c=%0d e=%b, want g=0 l=0 o=0 c=4 e=0", grant_o, locked_o, owner_o, credits_o, credit_err_o);
        end
        tick();
    endtask

    task automatic test_rr();
        logic [4:0] want [3] = '{5'b00001, 5'b10000, 5'b00001};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'b10001, 5'b10001, 5'b10001, 0);
            vectors++;
            if (grant_o !== want[i] || credits_o !== 3'(4 - i)) begin
                miscompares++;
                $display("FAIL rr[%0d]: got g=%b c=%0d, want g=%b c=%0d", i, grant_o, credits_o, want[i], 4 - i);
            end
            tick();
        end
        drive(0, 0, 0, 0);
        vectors++;
        if (credits_o !== 3'd1) begin
            miscompares++;
            $display("FAIL rr_credits: got %0d want 1", credits_o);
        end
        tick();
    endtask

    task automatic test_wormhole();
        do_reset();
        drive(5'b00010, 5'b00010, 5'b00010, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(5'b01110, i == 0 ? 5'b01110 : 5'b01010, i == 3 ? 5'b00100 : 5'b0, 1);
            vectors++;
            if (grant_o !== 5'b00100 || locked_o !== (i != 0)) begin
                miscompares++;
                $display("FAIL wormhole[%0d]: got g=%b l=%b, want g=00100 l=%b", i, grant_o, locked_o, i != 0);
            end
            tick();
        end
        drive(5'b01010, 5'b01010, 5'b0, 0);
        vectors++;
        if (grant_o !== 5'b01000 || locked_o !== 1'b0 || owner_o !== 3'd2) begin
            miscompares++;
            $display("FAIL wormhole_next: got g=%b l=%b o=%0d, want g=01000 l=0 o=2", grant_o, locked_o, owner_o);
        end
        tick();
    endtask

    task automatic test_credits();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(5'b00001, 5'b00001, 5'b00001, 0);
            vectors++;
            if (grant_o !== (i < 4 ? 5'b00001 : 5'b0) || credits_o !== 3'(i < 4 ? 4 - i : 0)) begin
                miscompares++;
                $display("FAIL credits[%0d]: got g=%b c=%0d, want g=%b c=%0d", i, grant_o, credits_o, i < 4 ? 5'b00001 : 5'b0, i < 4 ? 4 - i : 0);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(5'b00001, 5'b00001, 5'b00001, i == 0);
            vectors++;
            if (grant_o !== (i == 1 ? 5'b00001 : 5'b0) || credits_o !== 3'(i == 1)) begin
                miscompares++;
                $display("FAIL credit_return[%0d]: got g=%b c=%0d, want g=%b c=%0d", i, grant_o, credits_o, i == 1 ? 5'b00001 : 5'b0, i == 1);
            end
            tick();
        end
    endtask

    task automatic test_credit_edges();
        do_reset();
        repeat (2) begin drive(5'b00001, 5'b00001, 5'b00001, 0); tick(); end
        drive(5'b00001, 5'b00001, 5'b00001, 1);
        tick();
        drive(0, 0, 0, 0);
        vectors++;
        if (credits_o !== 3'd2) begin
            miscompares++;
            $display("FAIL grant_and_incr: got c=%0d want 2", credits_o);
        end
        tick();
        do_reset();
        drive(0, 0, 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0);
            vectors++;
            if (credits_o !== 3'd4 || credit_err_o !== 1'b1) begin
                miscompares++;
                $display("FAIL credit_err[%0d]: got c=%0d e=%b, want c=4 e=1", i, credits_o, credit_err_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(5'b01000, 5'b01000, 0, 0);
        tick();
        drive(5'b01000, 0, 0, 0);
        tick();
        rst = 1; #1;
        vectors++;
        if (locked_o !== 1'b0 || grant_o !== 5'b0 || credits_o !== 3'd4) begin
            miscompares++;
            $display("FAIL reset_mid: got l=%b g=%b c=%0d, want l=0 g=0 c=4", locked_o, grant_o, credits_o);
        end
        do_reset();
        drive(5'b01001, 5'b01001, 0, 0);
        vectors++;
        if (grant_o !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_prio: got g=%b want 00001", grant_o);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 9) < 4);
            vectors++;
            if (grant_o !== m_grant() || locked_o !== 1'(m_locked) || owner_o !== 3'(m_owner) || credits_o !== 3'(m_cred) || credit_err_o !== 1'(m_err)) begin
                miscompares++;
                $display("FAIL random[%0d]: got g=%b l=%b o=%0d c=%0d e=%b, want g=%b l=%0d o=%0d c=%0d e=%0d", n, grant_o, locked_o, owner_o, credits_o, credit_err_o, m_grant(), m_locked, m_owner, m_cred, m_err);
            end
            tick();
            if (n % 150 == 149) do_reset();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rr();
        test_wormhole();
        test_credits();
        test_credit_edges();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_output_arbiter.md
Name: rr_output_arbiter

Overview:
Per-output-port wormhole scheduler for the 5-port NoC router. One instance sits in front of each crossbar output. It shares that output among the five input buffers using round-robin priority. Once a head flit wins, the output stays locked to that input until the tail flit passes. A flit is granted only if the downstream router has buffer space, tracked by a local credit counter.

Parameters:
NPORTS, 5, number of requesting input ports (0=north, 1=south, 2=east, 3=west, 4=local)
MAX_CREDITS, 4, downstream buffer depth; value loaded into the credit counter at reset
CREDIT_W, 3, credit counter width; must hold MAX_CREDITS
TIMEOUT, 15, idle-owner cycles before forced release (optional feature only)

Ports:
clk  input  1  router clock
rst  input  1  asynchronous, active-high reset
req_i  input  NPORTS  input i has a flit routed to this output
head_i  input  NPORTS  flit at input i is a head flit
tail_i  input  NPORTS  flit at input i is a tail flit; head and tail both set = single-flit packet
credit_incr_i  input  1  downstream freed one buffer slot
grant_o  output  NPORTS  one-hot or zero; flit from input i transfers this cycle (drives buffer pop and xbar select)
locked_o  output  1  output is mid-packet
owner_o  output  3  index of the current or last owner
credits_o  output  CREDIT_W  current credit count
credit_err_o  output  1  sticky flag: credit increment seen while already at MAX_CREDITS

Behaviour:
- Reset (async, any time including mid-packet):
  - state=IDLE; locked_o=0; grant_o=0; owner_o=0; credits_o=MAX_CREDITS; credit_err_o=0.
  - Priority pointer ptr=NPORTS-1, so port 0 has first priority after reset.
- grant_o is combinational from registered state and the current inputs: zero-cycle latency. All state updates on posedge clk.
- IDLE state:
  - Eligible inputs = req_i & head_i. Requests without head are ignored.
  - Winner = first eligible index searching ptr+1, ptr+2, … with wrap at NPORTS-1 → 0.
  - If a winner exists and credits>0: grant_o[winner]=1; owner_o<=winner.
    - If tail_i[winner]=1: stay IDLE, ptr<=winner.
    - Otherwise: go LOCKED, locked_o<=1.
  - If credits==0: grant_o=0; no state change and ptr unchanged.
- LOCKED state:
  - grant_o[owner]=1 iff req_i[owner] && credits>0.
  - Requests from other ports are ignored. head_i of the owner is ignored (treated as a body flit).
  - On a granted flit with tail_i[owner]=1: next state IDLE, locked_o<=0, ptr<=owner.
  - A new head can be granted no earlier than the following cycle.
- Credits:
  - Decrement on any granted flit; increment on credit_incr_i.
  - Both in the same cycle: unchanged.
  - Never goes below 0; grants are blocked at 0.
  - Increment at MAX_CREDITS without a simultaneous grant: saturate and set credit_err_o (cleared only by rst).
- Fairness: after a port finishes a packet it has lowest priority. Any continuously eligible port is served within NPORTS-1 packets.

Optional Feature:
Macro LOCK_TIMEOUT_EN.
- Defined:
  - Adds output timeout_o (1 bit, reset 0).
  - A counter runs in LOCKED while req_i[owner]=0 and resets on any owner request.
  - When the counter reaches TIMEOUT: force IDLE, locked_o<=0, ptr<=owner, pulse timeout_o for one cycle. Credits are untouched.
- Not defined: no port, no counter; LOCKED persists indefinitely until the tail flit.

Test Plan:
- Reset, then req_i=5'b10001 with head+tail on both, credits=4 → grant port 0, next cycle port 4, then port 0; credits_o goes 4→3→2→1.
- Port 2 sends head, 2 body flits, then tail while ports 1 and 3 hold head requests → grant_o=5'b00100 for 4 consecutive cycles, locked_o=1 for 3 cycles, then port 3 is granted (ptr=2).
- MAX_CREDITS=4, no credit_incr_i, port 0 streams 6 flits → 4 grants, then grant_o=0 with credits_o=0; one credit_incr_i pulse → exactly one more grant.
- Grant and credit_incr_i in the same cycle at credits=2 → credits_o stays 2. credit_incr_i at credits=4 with no grant → credits_o=4, credit_err_o=1 and sticky.
- Assert rst while locked to port 3 mid-packet → immediately locked_o=0, grant_o=0, credits_o=4. After release, heads on ports 3 and 0 → port 0 is granted first.
- With LOCK_TIMEOUT_EN: owner 1 drops req for 15 cycles → timeout_o pulses once, locked_o=0, and a pending head on port 2 is granted the next cycle.
